// File: rtl/vertex_triangle_assembler_if.sv
// vertex_triangle_assembler_if: vertex input stream and triangle output stream of the assembler
interface vertex_triangle_assembler_if #(
  parameter int DATAWIDTH      = 12,
  parameter int DEPTH_FRACBITS = 11,
  parameter int CNT_WIDTH      = 16
);
  logic signed [DATAWIDTH-1:0]     i_vertex_pixel [2];
  logic signed [DEPTH_FRACBITS:0]  i_vertex_z;
  logic                            i_vertex_dv;
  logic                            i_vertex_invalid;
  logic                            o_ready;
  logic signed [DATAWIDTH-1:0]     o_tri_pixel [3][2];
  logic signed [DEPTH_FRACBITS:0]  o_tri_z [3];
  logic signed [2*DATAWIDTH+1:0]   o_tri_area;
  logic [DATAWIDTH-1:0]            o_bbox_min [2];
  logic [DATAWIDTH-1:0]            o_bbox_max [2];
  logic                            o_tri_dv;
  logic                            i_tri_ready;
  logic                            o_tri_dropped;
  logic [CNT_WIDTH-1:0]            o_tri_count;
  logic [CNT_WIDTH-1:0]            o_drop_count;
  modport master (
    output i_vertex_pixel, i_vertex_z, i_vertex_dv, i_vertex_invalid, i_tri_ready,
    input  o_ready, o_tri_pixel, o_tri_z, o_tri_area, o_bbox_min, o_bbox_max,
           o_tri_dv, o_tri_dropped, o_tri_count, o_drop_count
  );
  modport slave (
    input  i_vertex_pixel, i_vertex_z, i_vertex_dv, i_vertex_invalid, i_tri_ready,
    output o_ready, o_tri_pixel, o_tri_z, o_tri_area, o_bbox_min, o_bbox_max,
           o_tri_dv, o_tri_dropped, o_tri_count, o_drop_count
  );
endinterface

// File: rtl/vertex_triangle_assembler.sv
// vertex_triangle_assembler: groups vertices into triangles, culls bad ones, emits area and clamped bbox; define VTA_BACKFACE_CULL_EN to also drop negative-area triangles
module vertex_triangle_assembler #(
  parameter int DATAWIDTH      = 12,
  parameter int DEPTH_FRACBITS = 11,
  parameter int SCREEN_WIDTH   = 320,
  parameter int SCREEN_HEIGHT  = 320,
  parameter int CNT_WIDTH      = 16
) (
  input logic clk,
  input logic rstn,
  vertex_triangle_assembler_if.slave bus
);
  localparam int DW = DATAWIDTH;
  localparam int ZW = DEPTH_FRACBITS + 1;
  localparam int AW = 2 * DATAWIDTH + 2;
  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] CHECK   = 2'd1;
  localparam logic [1:0] EMIT    = 2'd2;
  localparam logic signed [DW-1:0] X_LIM = DW'(SCREEN_WIDTH - 1);
  localparam logic signed [DW-1:0] Y_LIM = DW'(SCREEN_HEIGHT - 1);

  logic [1:0]           state_q, state_d, idx_q, idx_d;
  logic                 poison_q, poison_d, dv_q, dv_d, dropped_q, dropped_d;
  logic signed [DW-1:0] sx_q [3], sx_d [3], sy_q [3], sy_d [3];
  logic signed [ZW-1:0] sz_q [3], sz_d [3];
  logic signed [DW-1:0] px_q [3][2], px_d [3][2];
  logic signed [ZW-1:0] pz_q [3], pz_d [3];
  logic signed [AW-1:0] area_q, area_d;
  logic [DW-1:0]        bmin_q [2], bmin_d [2], bmax_q [2], bmax_d [2];
  logic [CNT_WIDTH-1:0] tri_cnt_q, tri_cnt_d, drop_cnt_q, drop_cnt_d;
  logic                 ready, ev, cull, drop;
  logic signed [AW-1:0] dx1, dy1, dx2, dy2, area;
  logic signed [DW-1:0] mnx, mny, mxx, mxy;

  function automatic logic signed [DW-1:0] smin(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    return a < b ? a : b;
  endfunction

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    return a > b ? a : b;
  endfunction

  function automatic logic [DW-1:0] clamp(input logic signed [DW-1:0] v, input logic signed [DW-1:0] lim);
    return v[DW-1] ? '0 : (v > lim ? lim : v);
  endfunction

  assign ready = state_q == COLLECT;
  assign ev    = ready & (bus.i_vertex_dv | bus.i_vertex_invalid);

  // Triangle geometry from the three collected slots: doubled signed area and raw bbox
  always_comb begin
    dx1  = AW'(sx_q[1]) - AW'(sx_q[0]);
    dy1  = AW'(sy_q[1]) - AW'(sy_q[0]);
    dx2  = AW'(sx_q[2]) - AW'(sx_q[0]);
    dy2  = AW'(sy_q[2]) - AW'(sy_q[0]);
    area = dx1 * dy2 - dx2 * dy1;
    mnx  = smin(smin(sx_q[0], sx_q[1]), sx_q[2]);
    mny  = smin(smin(sy_q[0], sy_q[1]), sy_q[2]);
    mxx  = smax(smax(sx_q[0], sx_q[1]), sx_q[2]);
    mxy  = smax(smax(sy_q[0], sy_q[1]), sy_q[2]);
  end

`ifdef VTA_BACKFACE_CULL_EN
  assign cull = area[AW-1];
`else
  assign cull = 1'b0;
`endif

  assign drop = poison_q | (area == '0) | mxx[DW-1] | mxy[DW-1] | (mnx > X_LIM) | (mny > Y_LIM) | cull;

  // Vertex slot capture; each accepted event writes the slot picked by the running index
  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    sz_d = sz_q;
    if (ev) begin
      sx_d[idx_q] = bus.i_vertex_pixel[0];
      sy_d[idx_q] = bus.i_vertex_pixel[1];
      sz_d[idx_q] = bus.i_vertex_z;
    end
  end

  // Control: collect three events, judge the triangle for one cycle, then hold it until taken
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    poison_d   = poison_q;
    dv_d       = dv_q;
    dropped_d  = 1'b0;
    tri_cnt_d  = tri_cnt_q;
    drop_cnt_d = drop_cnt_q;
    px_d       = px_q;
    pz_d       = pz_q;
    area_d     = area_q;
    bmin_d     = bmin_q;
    bmax_d     = bmax_q;
    if (ev) begin
      idx_d    = idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1;
      state_d  = idx_q == 2'd2 ? CHECK : COLLECT;
      poison_d = poison_q | bus.i_vertex_invalid;
    end
    if (state_q == CHECK) begin
      poison_d = 1'b0;
      if (drop) begin
        dropped_d  = 1'b1;
        drop_cnt_d = drop_cnt_q + 1'b1;
        state_d    = COLLECT;
      end else begin
        for (int i = 0; i < 3; i++) begin
          px_d[i][0] = sx_q[i];
          px_d[i][1] = sy_q[i];
          pz_d[i]    = sz_q[i];
        end
        area_d    = area;
        bmin_d[0] = clamp(mnx, X_LIM);
        bmin_d[1] = clamp(mny, Y_LIM);
        bmax_d[0] = clamp(mxx, X_LIM);
        bmax_d[1] = clamp(mxy, Y_LIM);
        dv_d      = 1'b1;
        state_d   = EMIT;
      end
    end
    if (state_q == EMIT && bus.i_tri_ready) begin
      dv_d      = 1'b0;
      tri_cnt_d = tri_cnt_q + 1'b1;
      state_d   = COLLECT;
    end
  end

  // State and output registers; reset abandons any partial or pending triangle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= COLLECT;
      idx_q      <= '0;
      poison_q   <= 1'b0;
      dv_q       <= 1'b0;
      dropped_q  <= 1'b0;
      tri_cnt_q  <= '0;
      drop_cnt_q <= '0;
      sx_q       <= '{default: '0};
      sy_q       <= '{default: '0};
      sz_q       <= '{default: '0};
      px_q       <= '{default: '0};
      pz_q       <= '{default: '0};
      area_q     <= '0;
      bmin_q     <= '{default: '0};
      bmax_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      poison_q   <= poison_d;
      dv_q       <= dv_d;
      dropped_q  <= dropped_d;
      tri_cnt_q  <= tri_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      sz_q       <= sz_d;
      px_q       <= px_d;
      pz_q       <= pz_d;
      area_q     <= area_d;
      bmin_q     <= bmin_d;
      bmax_q     <= bmax_d;
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_tri_pixel   = px_q;
  assign bus.o_tri_z       = pz_q;
  assign bus.o_tri_area    = area_q;
  assign bus.o_bbox_min    = bmin_q;
  assign bus.o_bbox_max    = bmax_q;
  assign bus.o_tri_dv      = dv_q;
  assign bus.o_tri_dropped = dropped_q;
  assign bus.o_tri_count   = tri_cnt_q;
  assign bus.o_drop_count  = drop_cnt_q;
endmodule

// File: tb/tb_vertex_triangle_assembler.sv
// tb_vertex_triangle_assembler: directed and random triangles checked against an arithmetic reference model
module tb_vertex_triangle_assembler;
  localparam int DW = 12;
  localparam int FB = 11;
  localparam int ZW = FB + 1;
  localparam int CW = 16;
  localparam int SW = 320;
  localparam int SH = 320;
`ifdef VTA_BACKFACE_CULL_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0, bad = 0, exp_tri = 0, exp_drop = 0;
  int vx [3], vy [3], vz [3];
  bit e_drop;
  int e_area;
  int e_bb [4];

  always #5 clk = ~clk;

  vertex_triangle_assembler_if #(.DATAWIDTH(DW), .DEPTH_FRACBITS(FB), .CNT_WIDTH(CW)) bus ();

  vertex_triangle_assembler #(
    .DATAWIDTH(DW), .DEPTH_FRACBITS(FB), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lim(input int v, input int hi);
    return v < 0 ? 0 : (v > hi ? hi : v);
  endfunction

  task automatic model(input bit pois);
    int mnx, mny, mxx, mxy;
    e_area = (vx[1] - vx[0]) * (vy[2] - vy[0]) - (vx[2] - vx[0]) * (vy[1] - vy[0]);
    mnx = vx[0]; mxx = vx[0]; mny = vy[0]; mxy = vy[0];
    for (int i = 1; i < 3; i++) begin
      if (vx[i] < mnx) mnx = vx[i];
      if (vx[i] > mxx) mxx = vx[i];
      if (vy[i] < mny) mny = vy[i];
      if (vy[i] > mxy) mxy = vy[i];
    end
    e_drop = pois || e_area == 0 || mxx < 0 || mxy < 0 || mnx > SW - 1 || mny > SH - 1 || (CULL && e_area < 0);
    e_bb[0] = lim(mnx, SW - 1);
    e_bb[1] = lim(mny, SH - 1);
    e_bb[2] = lim(mxx, SW - 1);
    e_bb[3] = lim(mxy, SH - 1);
  endtask

  task automatic put_vertex(input int x, input int y, input int z, input bit inv);
    bus.i_vertex_pixel[0] = DW'(x);
    bus.i_vertex_pixel[1] = DW'(y);
    bus.i_vertex_z = ZW'(z);
    bus.i_vertex_dv = inv ? bit'($urandom_range(0, 1)) : 1'b1;
    bus.i_vertex_invalid = inv;
    tick();
    bus.i_vertex_dv = 1'b0;
    bus.i_vertex_invalid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.i_vertex_dv = 1'b0;
    bus.i_vertex_invalid = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    exp_tri = 0;
    exp_drop = 0;
  endtask

  task automatic run_tri(input bit [2:0] inv, input int stall, input string tag);
    model(|inv);
    bus.i_tri_ready = stall == 0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, ":ready_collect"}, bus.o_ready, 1);
      put_vertex(vx[i], vy[i], vz[i], inv[i]);
    end
    chk({tag, ":ready_check"}, bus.o_ready, 0);
    chk({tag, ":dv_check"}, bus.o_tri_dv, 0);
    tick();
    chk({tag, ":dropped"}, bus.o_tri_dropped, e_drop);
    chk({tag, ":dv"}, bus.o_tri_dv, !e_drop);
    if (e_drop) begin
      exp_drop++;
      chk({tag, ":drop_count"}, bus.o_drop_count, exp_drop % 65536);
      tick();
      chk({tag, ":drop_pulse_end"}, bus.o_tri_dropped, 0);
    end else begin
      chk({tag, ":area"}, bus.o_tri_area, e_area);
      for (int i = 0; i < 3; i++) begin
        chk({tag, ":px"}, bus.o_tri_pixel[i][0], vx[i]);
        chk({tag, ":py"}, bus.o_tri_pixel[i][1], vy[i]);
        chk({tag, ":z"}, bus.o_tri_z[i], vz[i]);
      end
      chk({tag, ":bbminx"}, bus.o_bbox_min[0], e_bb[0]);
      chk({tag, ":bbminy"}, bus.o_bbox_min[1], e_bb[1]);
      chk({tag, ":bbmaxx"}, bus.o_bbox_max[0], e_bb[2]);
      chk({tag, ":bbmaxy"}, bus.o_bbox_max[1], e_bb[3]);
      for (int c = 0; c < stall; c++) begin
        bus.i_vertex_pixel[0] = DW'($urandom_range(0, 300));
        bus.i_vertex_pixel[1] = DW'($urandom_range(0, 300));
        bus.i_vertex_dv = 1'b1;
        tick();
        chk({tag, ":stall_dv"}, bus.o_tri_dv, 1);
        chk({tag, ":stall_ready"}, bus.o_ready, 0);
        chk({tag, ":stall_area"}, bus.o_tri_area, e_area);
        chk({tag, ":stall_px0"}, bus.o_tri_pixel[0][0], vx[0]);
        chk({tag, ":stall_bbmaxy"}, bus.o_bbox_max[1], e_bb[3]);
      end
      bus.i_vertex_dv = 1'b0;
      bus.i_tri_ready = 1'b1;
      tick();
      exp_tri++;
      chk({tag, ":dv_after"}, bus.o_tri_dv, 0);
      chk({tag, ":ready_after"}, bus.o_ready, 1);
      chk({tag, ":tri_count"}, bus.o_tri_count, exp_tri % 65536);
    end
  endtask

  initial begin
    bus.i_vertex_pixel[0] = '0;
    bus.i_vertex_pixel[1] = '0;
    bus.i_vertex_z = '0;
    bus.i_vertex_dv = 1'b0;
    bus.i_vertex_invalid = 1'b0;
    bus.i_tri_ready = 1'b1;
    vz = '{256, 256, 256};
    do_reset();
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_dv", bus.o_tri_dv, 0);
    chk("rst_dropped", bus.o_tri_dropped, 0);
    chk("rst_area", bus.o_tri_area, 0);
    chk("rst_bbmaxx", bus.o_bbox_max[0], 0);
    chk("rst_tri_count", bus.o_tri_count, 0);
    chk("rst_drop_count", bus.o_drop_count, 0);

    vx = '{10, 50, 10};   vy = '{10, 10, 50};   run_tri(3'b000, 0, "ccw");
    vx = '{10, 10, 50};   vy = '{10, 50, 10};   run_tri(3'b000, 0, "cw");
    vx = '{0, 10, 20};    vy = '{0, 10, 20};    run_tri(3'b000, 0, "collinear");
    vx = '{10, 50, 10};   vy = '{10, 10, 50};   run_tri(3'b010, 0, "poison");
    vx = '{20, 60, 20};   vy = '{20, 20, 70};   run_tri(3'b000, 0, "after_poison");
    vx = '{-50, -10, -50}; vy = '{-50, -50, -10}; run_tri(3'b000, 0, "offscreen");
    vx = '{400, 500, 400}; vy = '{10, 10, 50};  run_tri(3'b000, 0, "offscreen_right");
    vx = '{-20, 100, 5};  vy = '{5, 5, 400};    run_tri(3'b000, 0, "clamp");
    vz = '{-7, 2047, 300};
    vx = '{30, 90, 40};   vy = '{30, 35, 100};  run_tri(3'b000, 5, "backpressure");

    vx = '{1, 2, 3}; vy = '{4, 5, 6};
    put_vertex(100, 100, 1, 1'b0);
    put_vertex(200, 100, 1, 1'b1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    exp_tri = 0;
    exp_drop = 0;
    chk("rst_partial_ready", bus.o_ready, 1);
    chk("rst_partial_tri_count", bus.o_tri_count, 0);
    chk("rst_partial_drop_count", bus.o_drop_count, 0);
    vx = '{5, 60, 5};     vy = '{5, 5, 60};     run_tri(3'b000, 0, "after_partial_rst");

    vx = '{15, 70, 15};   vy = '{15, 15, 90};
    bus.i_tri_ready = 1'b0;
    for (int i = 0; i < 3; i++) put_vertex(vx[i], vy[i], vz[i], 1'b0);
    tick();
    chk("emit_rst_pre_dv", bus.o_tri_dv, 1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    bus.i_tri_ready = 1'b1;
    exp_tri = 0;
    exp_drop = 0;
    chk("emit_rst_dv", bus.o_tri_dv, 0);
    chk("emit_rst_ready", bus.o_ready, 1);
    chk("emit_rst_tri_count", bus.o_tri_count, 0);
    chk("emit_rst_drop_count", bus.o_drop_count, 0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 3; i++) begin
        vx[i] = int'($urandom_range(0, 560)) - 120;
        vy[i] = int'($urandom_range(0, 560)) - 120;
        vz[i] = int'($urandom_range(0, 4095)) - 2048;
      end
      if ($urandom_range(0, 5) == 0) begin
        vx[2] = vx[0];
        vy[2] = vy[0];
      end
      run_tri($urandom_range(0, 7) == 0 ? 3'($urandom_range(1, 7)) : 3'b000, int'($urandom_range(0, 3)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
